// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch
//   Access sequencer sitting in front of a single-read-port register file.
//   Two source operands (Rn, Rm) are read in two consecutive cycles through
//   the one read port and presented to the datapath with a valid/ready
//   handshake. Writeback requests pass straight through to the write port.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   : a capture in RD_A/RD_B takes wb_data when the same-cycle
//                 writeback targets the register being read.
//     undefined : captures always take rf_dout, so a same-cycle write is
//                 not seen until the following cycle.
module regfile_operand_fetch #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    // fetch request
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rn,
    input  logic [AW-1:0] req_rm,
    // operands to datapath
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    // writeback request
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    // register file ports
    output logic [AW-1:0] readnum,
    input  logic [DW-1:0] rf_dout,
    output logic [AW-1:0] writenum,
    output logic          write,
    output logic [DW-1:0] data_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] rn_q;
    logic [AW-1:0] rm_q;
    logic [DW-1:0] rd_val;
    logic          accept;

    // Write port is a pure pass-through; reset masks the strobe so the
    // register file cannot be corrupted while the system is held in reset.
    assign write    = wb_valid & reset_n;
    assign writenum = wb_rd;
    assign data_in  = wb_data;

    // A request is only taken in IDLE, so requests never overlap.
    assign accept = (state == IDLE) && req_valid;

    // Read-data selection: optional same-cycle writeback forwarding.
`ifdef RF_BYPASS_EN
    always_comb begin
        rd_val = rf_dout;
        if (((state == RD_A) || (state == RD_B)) && wb_valid && (wb_rd == readnum)) begin
            rd_val = wb_data;
        end
    end
`else
    assign rd_val = rf_dout;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and outputs decoded purely from the registered state,
    // so op_ready never reaches req_ready/op_valid combinationally.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        readnum   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: begin
                readnum   = rn_q;
                state_nxt = RD_B;
            end
            RD_B: begin
                readnum   = rm_q;
                state_nxt = DONE;
            end
            DONE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the operand indices when a request is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rn_q <= '0;
            rm_q <= '0;
        end else if (accept) begin
            rn_q <= req_rn;
            rm_q <= req_rm;
        end
    end

    // Operand A is captured at the end of RD_A; it then holds until the
    // next fetch overwrites it, including through backpressure in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a <= '0;
        end else if (state == RD_A) begin
            op_a <= rd_val;
        end
    end

    // Operand B is captured at the end of RD_B with the same hold behaviour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_b <= '0;
        end else if (state == RD_B) begin
            op_b <= rd_val;
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb_regfile_operand_fetch
//   Bench for regfile_operand_fetch together with a behavioural 8x16 register
//   file. A shadow array holds the architectural register contents; expected
//   operands are derived from it using the read/write visibility rules.
module tb_regfile_operand_fetch;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 1 << AW;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rn    = '0;
    logic [AW-1:0] req_rm    = '0;
    logic          op_valid;
    logic          op_ready  = 1'b0;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid  = 1'b0;
    logic [AW-1:0] wb_rd     = '0;
    logic [DW-1:0] wb_data   = '0;
    logic [AW-1:0] readnum;
    logic [DW-1:0] rf_dout;
    logic [AW-1:0] writenum;
    logic          write;
    logic [DW-1:0] data_in;

    logic [DW-1:0] rf  [NR];
    logic [DW-1:0] mdl [NR];

    int total = 0;
    int bad   = 0;

    regfile_operand_fetch #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .readnum   (readnum),
        .rf_dout   (rf_dout),
        .writenum  (writenum),
        .write     (write),
        .data_in   (data_in)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on posedge.
    always @(posedge clk) begin
        if (write) rf[writenum] <= data_in;
    end
    assign rf_dout = rf[readnum];

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_rd    = r;
        wb_data  = d;
        #1;
        check("wb_passthru_write", 32'(write), 32'(1));
        check("wb_passthru_data", 32'(data_in), 32'(d));
        tick();
        wb_valid = 1'b0;
        mdl[r]   = d;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'(1));
    endtask

    // One complete fetch. Optionally issues a writeback while in RD_A and
    // holds op_ready low for bp cycles once operands are valid.
    task automatic fetch(input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                         input bit hz, input logic [AW-1:0] hr, input logic [DW-1:0] hd,
                         input int bp);
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        wait_ready();
        req_valid = 1'b1;
        req_rn    = rn;
        req_rm    = rm;
        tick();
        req_valid = 1'b0;
        check("rd_a_readnum", 32'(readnum), 32'(rn));
        check("rd_a_req_ready", 32'(req_ready), 32'(0));
        check("rd_a_op_valid", 32'(op_valid), 32'(0));
        ea = mdl[rn];
        if (hz) begin
`ifdef RF_BYPASS_EN
            if (hr == rn) ea = hd;
`endif
            wb_valid = 1'b1;
            wb_rd    = hr;
            wb_data  = hd;
        end
        tick();
        wb_valid = 1'b0;
        if (hz) mdl[hr] = hd;
        check("rd_b_readnum", 32'(readnum), 32'(rm));
        check("rd_b_op_valid", 32'(op_valid), 32'(0));
        eb = mdl[rm];
        tick();
        check("done_op_valid", 32'(op_valid), 32'(1));
        check("done_op_a", 32'(op_a), 32'(ea));
        check("done_op_b", 32'(op_b), 32'(eb));
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_op_valid", 32'(op_valid), 32'(1));
            check("bp_op_a", 32'(op_a), 32'(ea));
            check("bp_op_b", 32'(op_b), 32'(eb));
            check("bp_req_ready", 32'(req_ready), 32'(0));
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("post_hs_req_ready", 32'(req_ready), 32'(1));
        check("post_hs_op_valid", 32'(op_valid), 32'(0));
        check("post_hs_op_a_hold", 32'(op_a), 32'(ea));
        check("post_hs_op_b_hold", 32'(op_b), 32'(eb));
    endtask

    initial begin
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] v;
        int            acc[$];
        int            a0;

        // Reset state
        tick();
        tick();
        check("rst_op_valid", 32'(op_valid), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_op_a", 32'(op_a), 32'(0));
        check("rst_op_b", 32'(op_b), 32'(0));
        check("rst_readnum", 32'(readnum), 32'(0));
        wb_valid = 1'b1;
        #1;
        check("rst_write_forced", 32'(write), 32'(0));
        wb_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Fill the register file with random contents
        for (int i = 0; i < NR; i++) begin
            do_wb(AW'(i), DW'($urandom));
        end

        // Directed: R3/R5 fetch with 5 cycles of backpressure
        do_wb(3'd3, 16'h00A5);
        do_wb(3'd5, 16'h1234);
        fetch(3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 5);

        // Same-cycle hazard on R2; the second read of R2 (as Rm) sees BEEF
        do_wb(3'd2, 16'h0001);
        fetch(3'd2, 3'd2, 1'b1, 3'd2, 16'hBEEF, 0);
        fetch(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 0);
        check("hazard_next_fetch", 32'(op_a), 32'(16'hBEEF));

        // rn == rm
        do_wb(3'd7, 16'hFFFF);
        fetch(3'd7, 3'd7, 1'b0, 3'd0, 16'h0, 1);

        // Randomised fetches with random hazards and backpressure
        for (int k = 0; k < 12; k++) begin
            r1 = AW'($urandom);
            r2 = AW'($urandom);
            v  = DW'($urandom);
            fetch(r1, r2, bit'($urandom_range(0, 1)), (k % 2 == 0) ? r1 : AW'($urandom),
                  v, int'($urandom_range(0, 3)));
        end

        // Back-to-back requests with req_valid and op_ready held high
        wait_ready();
        r1 = AW'($urandom);
        r2 = AW'($urandom);
        req_rn    = r1;
        req_rm    = r2;
        req_valid = 1'b1;
        op_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) acc.push_back(i);
            if (op_valid) begin
                check("b2b_op_a", 32'(op_a), 32'(mdl[r1]));
                check("b2b_op_b", 32'(op_b), 32'(mdl[r2]));
            end
            tick();
        end
        req_valid = 1'b0;
        op_ready  = 1'b0;
        check("b2b_accept_count", 32'(acc.size()), 32'(5));
        a0 = acc.size() > 0 ? acc[0] : 0;
        for (int i = 1; i < acc.size(); i++) begin
            check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(4));
        end
        check("b2b_first_accept", 32'(a0), 32'(0));
        tick();
        tick();

        // Reset pulse while in RD_B
        do_wb(3'd1, DW'($urandom) | 16'h0001);
        fetch(3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 0);
        wait_ready();
        req_valid = 1'b1;
        req_rn    = 3'd1;
        req_rm    = 3'd6;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_readnum", 32'(readnum), 32'(6));
        check("pre_rst_op_a", 32'(op_a), 32'(mdl[1]));
        wb_valid = 1'b1;
        wb_rd    = 3'd4;
        wb_data  = 16'h5A5A;
        reset_n  = 1'b0;
        #1;
        check("async_rst_op_valid", 32'(op_valid), 32'(0));
        check("async_rst_op_a", 32'(op_a), 32'(0));
        check("async_rst_op_b", 32'(op_b), 32'(0));
        check("async_rst_readnum", 32'(readnum), 32'(0));
        check("async_rst_write", 32'(write), 32'(0));
        check("async_rst_req_ready", 32'(req_ready), 32'(1));
        tick();
        wb_valid = 1'b0;
        reset_n  = 1'b1;
        do_wb(3'd6, DW'($urandom));
        fetch(3'd4, 3'd6, 1'b0, 3'd0, 16'h0, 0);
        fetch(3'd1, 3'd6, 1'b0, 3'd0, 16'h0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
